// File: rtl/riscv_mon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_mon_pkg : shared types and constants for the riscv_soc test monitor
// Rev 1.0
// ----------------------------------------------------------------------------
package riscv_mon_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam int DONE_VAL = 1;
    localparam int PASS_VAL = 1;

    function automatic int trace_width(input int xlen);
        return 2 * xlen;
    endfunction

    localparam int TRACE_W = trace_width(32);

endpackage
`default_nettype wire

// File: rtl/monitor_trace_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// monitor_trace_fifo : circular jump-trace buffer with overflow flag and
//                      registered read port
// Rev 1.0
// ----------------------------------------------------------------------------
module monitor_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int OVWR  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rp_q, rp_d, wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdv_q;
    logic [WIDTH-1:0] rdd_q;
    logic             w_do_rd, w_push_new, w_mem_we, w_full;

    assign w_full  = (cnt_q == C_FULL);
    assign w_do_rd = rd_en_i && (cnt_q != '0);

    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        w_mem_we   = 1'b0;
        w_push_new = 1'b0;
        if (w_do_rd) begin
            rp_d = rp_q + AW'(1);
        end
        if (wr_en_i) begin
            // A same-cycle pop frees the oldest slot, so a full buffer still accepts
            if (!w_full || w_do_rd) begin
                w_mem_we   = 1'b1;
                w_push_new = 1'b1;
                wp_d       = wp_q + AW'(1);
            end else begin
                ovf_d = 1'b1;
                if (OVWR != 0) begin
                    w_mem_we = 1'b1;
                    wp_d     = wp_q + AW'(1);
                    rp_d     = rp_q + AW'(1);
                end
            end
        end
        if (w_push_new && !w_do_rd) begin
            cnt_d = cnt_q + CW'(1);
        end else if (w_do_rd && !w_push_new) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            rdv_q <= 1'b0;
            rdd_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            rdv_q <= w_do_rd;
            if (w_do_rd) begin
                rdd_q <= mem_q[rp_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wp_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = rdv_q;
    assign rd_data_o  = rdd_q;
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_test_monitor : end-of-test monitor (pass/fail/timeout + jump trace)
// Rev 1.0
// ----------------------------------------------------------------------------
module riscv_test_monitor
    import riscv_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TRACE_OVWR  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          jump_en,
    input  logic [XLEN-1:0]               pc_ex,
    input  logic [XLEN-1:0]               jump_addr,
    input  logic [XLEN-1:0]               done_reg,
    input  logic [XLEN-1:0]               pass_reg,
    input  logic [XLEN-1:0]               testnum_reg,
    output logic                          test_done,
    output logic                          test_pass,
    output logic                          test_fail,
    output logic                          test_timeout,
    output logic [XLEN-1:0]               fail_testnum,
    output logic [31:0]                   jump_count,
    input  logic                          trace_rd_en,
    output logic                          trace_rd_valid,
    output logic [2*XLEN-1:0]             trace_rd_data,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          trace_overflow
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0]   C_SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [31:0]     C_TO_LAST     = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    mon_state_e        state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [31:0]       to_cnt_q;
    logic [XLEN-1:0]   fnum_q, fnum_d;
    logic [31:0]       jc_q;
    logic              done_q, pass_q, fail_q, timeout_q;
    logic              w_active, w_to_hit, w_rec;

    assign w_active = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign w_to_hit = (TIMEOUT_CYC != 0) && w_active && (to_cnt_q == C_TO_LAST);
    assign w_rec    = jump_en && w_active;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        fnum_d   = fnum_q;
        case (state_q)
            ST_RUN: begin
                if (w_to_hit) begin
                    state_d = ST_TIMEOUT;
                end else if (done_reg == XLEN'(DONE_VAL)) begin
                    state_d  = ST_SETTLE;
                    settle_d = C_SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                // The watchdog takes priority over a coincident pass/fail sample
                if (w_to_hit) begin
                    state_d = ST_TIMEOUT;
                end else if (settle_q == '0) begin
                    state_d = (pass_reg == XLEN'(PASS_VAL)) ? ST_PASS : ST_FAIL;
                    fnum_d  = testnum_reg;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            settle_q  <= '0;
            to_cnt_q  <= '0;
            fnum_q    <= '0;
            jc_q      <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            fnum_q    <= fnum_d;
            if ((TIMEOUT_CYC != 0) && w_active) begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end
            if (w_rec && (jc_q != 32'hFFFF_FFFF)) begin
                jc_q <= jc_q + 32'd1;
            end
            done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
            pass_q    <= (state_d == ST_PASS);
            fail_q    <= (state_d == ST_FAIL);
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end

    monitor_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (2 * XLEN),
        .OVWR  (TRACE_OVWR)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (w_rec),
        .wr_data_i  ({pc_ex, jump_addr}),
        .rd_en_i    (trace_rd_en),
        .rd_valid_o (trace_rd_valid),
        .rd_data_o  (trace_rd_data),
        .count_o    (trace_count),
        .overflow_o (trace_overflow)
    );

    assign test_done    = done_q;
    assign test_pass    = pass_q;
    assign test_fail    = fail_q;
    assign test_timeout = timeout_q;
    assign fail_testnum = fnum_q;
    assign jump_count   = jc_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for riscv_test_monitor: two instances (overwrite+watchdog, drop+no watchdog)
// checked every cycle against an event-level model plus literal expectations.
module tb_riscv_test_monitor;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] pc_ex = '0, jump_addr = '0, done_reg = '0, pass_reg = '0, testnum_reg = '0;

    logic        d0_done, d0_pass, d0_fail, d0_to, d0_rdv, d0_ovf;
    logic        d1_done, d1_pass, d1_fail, d1_to, d1_rdv, d1_ovf;
    logic [31:0] d0_fnum, d0_jc, d1_fnum, d1_jc;
    logic [63:0] d0_rdd, d1_rdd;
    logic [2:0]  d0_cnt, d1_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(.XLEN(32), .TRACE_DEPTH(DEPTH), .SETTLE_CYC(SETTLE),
                         .TIMEOUT_CYC(50), .TRACE_OVWR(1)) u_dut0 (
        .clk(clk), .rst(rst), .jump_en(jump_en), .pc_ex(pc_ex), .jump_addr(jump_addr),
        .done_reg(done_reg), .pass_reg(pass_reg), .testnum_reg(testnum_reg),
        .test_done(d0_done), .test_pass(d0_pass), .test_fail(d0_fail), .test_timeout(d0_to),
        .fail_testnum(d0_fnum), .jump_count(d0_jc), .trace_rd_en(rd_en),
        .trace_rd_valid(d0_rdv), .trace_rd_data(d0_rdd), .trace_count(d0_cnt),
        .trace_overflow(d0_ovf));

    riscv_test_monitor #(.XLEN(32), .TRACE_DEPTH(DEPTH), .SETTLE_CYC(SETTLE),
                         .TIMEOUT_CYC(0), .TRACE_OVWR(0)) u_dut1 (
        .clk(clk), .rst(rst), .jump_en(jump_en), .pc_ex(pc_ex), .jump_addr(jump_addr),
        .done_reg(done_reg), .pass_reg(pass_reg), .testnum_reg(testnum_reg),
        .test_done(d1_done), .test_pass(d1_pass), .test_fail(d1_fail), .test_timeout(d1_to),
        .fail_testnum(d1_fnum), .jump_count(d1_jc), .trace_rd_en(rd_en),
        .trace_rd_valid(d1_rdv), .trace_rd_data(d1_rdd), .trace_count(d1_cnt),
        .trace_overflow(d1_ovf));

    // ---------------- model: outcome by edge index, trace as a bounded queue
    int          cyc;
    bit          model_ok = 1'b0;
    int          m_term [2];        // 0 none, 1 pass, 2 fail, 3 timeout
    int          m_done_edge [2];
    logic [31:0] m_fnum [2];
    logic [31:0] m_jc [2];
    bit          m_ovf [2];
    bit          m_rdv [2];
    logic [63:0] m_rdd [2];
    logic [63:0] mq0 [$];
    logic [63:0] mq1 [$];

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [63:0] qpop(input int k);
        if (k == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    task automatic qpush(input int k, input logic [63:0] v);
        if (k == 0) mq0.push_back(v);
        else        mq1.push_back(v);
    endtask

    task automatic model_reset();
        cyc = 0;
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_term[k] = 0; m_done_edge[k] = -1; m_fnum[k] = '0; m_jc[k] = '0;
            m_ovf[k] = 1'b0; m_rdv[k] = 1'b0; m_rdd[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input int ovwr, input int to_cyc);
        bit act;
        bit popd;
        act = (m_term[k] == 0);
        if (act && to_cyc != 0 && cyc == to_cyc - 1) begin
            m_term[k] = 3;
        end else if (act && m_done_edge[k] >= 0 && cyc == m_done_edge[k] + SETTLE) begin
            m_term[k] = (pass_reg == 32'd1) ? 1 : 2;
            m_fnum[k] = testnum_reg;
        end else if (act && m_done_edge[k] < 0 && done_reg == 32'd1) begin
            m_done_edge[k] = cyc;
        end
        popd = rd_en && (qsize(k) > 0);
        m_rdv[k] = popd;
        if (popd) m_rdd[k] = qpop(k);
        if (act && jump_en) begin
            if (m_jc[k] != 32'hFFFF_FFFF) m_jc[k] = m_jc[k] + 32'd1;
            if (qsize(k) < DEPTH) begin
                qpush(k, {pc_ex, jump_addr});
            end else begin
                m_ovf[k] = 1'b1;
                if (ovwr != 0) begin
                    void'(qpop(k));
                    qpush(k, {pc_ex, jump_addr});
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            model_ok = 1'b1;
        end else begin
            model_step(0, 1, 50);
            model_step(1, 0, 0);
            cyc = cyc + 1;
        end
    end

    // ---------------- checking
    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[dut%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
    endtask

    task automatic cmp_inst(input int k, input logic done, input logic pass, input logic fail,
                            input logic to, input logic [31:0] fnum, input logic [31:0] jc,
                            input logic [2:0] cnt, input logic ovf, input logic rdv,
                            input logic [63:0] rdd);
        chk("test_done",      k, 64'(done), 64'(m_term[k] != 0));
        chk("test_pass",      k, 64'(pass), 64'(m_term[k] == 1));
        chk("test_fail",      k, 64'(fail), 64'(m_term[k] == 2));
        chk("test_timeout",   k, 64'(to),   64'(m_term[k] == 3));
        chk("fail_testnum",   k, 64'(fnum), 64'(m_fnum[k]));
        chk("jump_count",     k, 64'(jc),   64'(m_jc[k]));
        chk("trace_count",    k, 64'(cnt),  64'(qsize(k)));
        chk("trace_overflow", k, 64'(ovf),  64'(m_ovf[k]));
        chk("trace_rd_valid", k, 64'(rdv),  64'(m_rdv[k]));
        if (m_rdv[k]) chk("trace_rd_data", k, rdd, m_rdd[k]);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp_inst(0, d0_done, d0_pass, d0_fail, d0_to, d0_fnum, d0_jc, d0_cnt, d0_ovf, d0_rdv, d0_rdd);
            cmp_inst(1, d1_done, d1_pass, d1_fail, d1_to, d1_fnum, d1_jc, d1_cnt, d1_ovf, d1_rdv, d1_rdd);
        end
    end

    // ---------------- stimulus
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_inputs();
        jump_en = 1'b0; rd_en = 1'b0; pc_ex = '0; jump_addr = '0;
        done_reg = '0; pass_reg = '0; testnum_reg = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic jump(input logic [31:0] from, input logic [31:0] to);
        jump_en = 1'b1; pc_ex = from; jump_addr = to;
        step();
        jump_en = 1'b0;
    endtask

    initial begin
        // done seen at edge 10 -> pass visible after edge 10+SETTLE
        do_reset();
        chk("lit_reset_done", 0, 64'(d0_done), 64'd0);
        chk("lit_reset_cnt",  0, 64'(d0_cnt),  64'd0);
        step(10);
        done_reg = 32'd1; pass_reg = 32'd1; testnum_reg = 32'd5;
        step(3);
        chk("lit_pass_early", 0, 64'(d0_pass), 64'd0);
        step();
        chk("lit_pass",       0, 64'(d0_pass), 64'd1);
        chk("lit_pass_done",  1, 64'(d1_done), 64'd1);
        step(2);

        // fail with testnum 7; done pulse drops during SETTLE
        do_reset();
        done_reg = 32'd1; pass_reg = 32'd0; testnum_reg = 32'd7;
        step();
        done_reg = 32'd0;
        step(4);
        chk("lit_fail",      0, 64'(d0_fail), 64'd1);
        chk("lit_fail_num",  0, 64'(d0_fnum), 64'd7);
        chk("lit_fail_pass", 1, 64'(d1_pass), 64'd0);

        // near-miss done value: only the exact value 1 counts
        do_reset();
        done_reg = 32'h0000_0101;
        step(49);
        chk("lit_to_early", 0, 64'(d0_to), 64'd0);
        step();
        chk("lit_timeout",  0, 64'(d0_to), 64'd1);
        chk("lit_no_done1", 1, 64'(d1_done), 64'd0);
        done_reg = 32'd1; pass_reg = 32'd1;
        jump(32'h0000_0200, 32'h0000_0300);
        step(5);
        chk("lit_to_sticky", 0, 64'(d0_pass), 64'd0);
        chk("lit_to_nojump", 0, 64'(d0_jc),   64'd0);

        // six jumps into a depth-4 trace, then five pops
        do_reset();
        for (int i = 0; i < 6; i++) jump(32'h10 + 32'(4 * i), 32'h40 + 32'(4 * i));
        chk("lit_cnt_ovwr",  0, 64'(d0_cnt), 64'd4);
        chk("lit_ovf_ovwr",  0, 64'(d0_ovf), 64'd1);
        chk("lit_ovf_drop",  1, 64'(d1_ovf), 64'd1);
        chk("lit_jc_drop",   1, 64'(d1_jc),  64'd6);
        rd_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            step();
            chk("lit_pop_ovwr", 0, d0_rdd, {32'h10 + 32'(4 * (p + 2)), 32'h40 + 32'(4 * (p + 2))});
            chk("lit_pop_drop", 1, d1_rdd, {32'h10 + 32'(4 * p), 32'h40 + 32'(4 * p)});
        end
        step();
        chk("lit_pop_empty", 0, 64'(d0_rdv), 64'd0);
        rd_en = 1'b0;
        step();

        // full trace with simultaneous push and pop, then reset mid-SETTLE
        do_reset();
        for (int i = 0; i < 4; i++) jump(32'h1000 + 32'(i), 32'h2000 + 32'(i));
        rd_en = 1'b1;
        jump(32'h1004, 32'h2004);
        rd_en = 1'b0;
        chk("lit_rw_cnt",  0, 64'(d0_cnt), 64'd4);
        chk("lit_rw_ovf",  0, 64'(d0_ovf), 64'd0);
        chk("lit_rw_ovf1", 1, 64'(d1_ovf), 64'd0);
        chk("lit_rw_data", 0, d0_rdd, {32'h1000, 32'h2000});
        done_reg = 32'd1; pass_reg = 32'd0; testnum_reg = 32'd9;
        step(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_rst_done", 0, 64'(d0_done), 64'd0);
        chk("lit_rst_fnum", 0, 64'(d0_fnum), 64'd0);
        chk("lit_rst_jc",   0, 64'(d0_jc),   64'd0);
        chk("lit_rst_cnt",  0, 64'(d0_cnt),  64'd0);
        pass_reg = 32'd1;
        step(5);
        chk("lit_rerun_pass", 0, 64'(d0_pass), 64'd1);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
